// File: rtl/xmit_pkg.sv
// xmit_pkg: shared state, priority-mode and framing constants for the frame generator
package xmit_pkg;
  typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, GAP} state_t;
  localparam logic [1:0] PRI_LO   = 2'd0;
  localparam logic [1:0] PRI_HI   = 2'd1;
  localparam logic [1:0] PRI_ALT  = 2'd2;
  localparam logic [1:0] PRI_RAND = 2'd3;
  localparam logic [7:0] HDR_BYTE = 8'hFF;
  localparam logic [7:0] TRL_BYTE = 8'h00;
  // Control block is the length repeated in both halves; callers truncate to 2*w bits
  function automatic logic [63:0] ctrl_blk(input logic [31:0] len, input int unsigned w);
    return ({32'd0, len} << w) | {32'd0, len};
  endfunction
endpackage

// File: rtl/xmit_prio_lfsr.sv
// xmit_prio_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11) supplying random frame priority
module xmit_prio_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_adv,
  output logic o_bit
);
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_lfsr <= SEED;
    else if (i_adv) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign o_bit = r_lfsr[0];
endmodule

// File: rtl/xmit_frame_gen.sv
// xmit_frame_gen: run-time configurable header/payload/trailer frame source for transmit-block bring-up
module xmit_frame_gen
  import xmit_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 12,
  parameter int CNT_W   = 16,
  parameter int HDR_LEN = 4,
  parameter int TRL_LEN = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_num_frames,
  input  logic [7:0]         cfg_gap,
  input  logic [1:0]         cfg_pri_mode,
  input  logic               m_discard_en,
  output logic [DATA_W-1:0]  f_data_in,
  output logic               f_rec_data_valid,
  output logic               f_rec_frame_valid,
  output logic [2*LEN_W-1:0] f_ctrl_in,
  output logic               f_hi_priority,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   frames_sent,
  output logic [CNT_W-1:0]   discard_cnt
);
  localparam int MIN_LEN = HDR_LEN + TRL_LEN + 1;
  state_t           r_state, w_state_nx;
  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_nx, w_cnt_inc, w_pay_last, w_gap_last;
  logic [CNT_W-1:0] r_num, r_frames, r_disc, w_frames_inc;
  logic [7:0]       r_gap;
  logic [1:0]       r_mode, w_mode;
  logic r_abort, r_done, r_cfg_err, r_pri, r_alt;
  logic w_go, w_abort, w_last, w_accept, w_err, w_new, w_exit, w_frame_end;
  logic w_alt_cur, w_pri_nx, w_lfsr_bit, w_hdr0, w_in_frame;

  assign w_go         = ~stall;
  assign w_abort      = r_abort | abort;
  assign w_frames_inc = r_frames + CNT_W'(1);
  assign w_last       = (r_num != '0) && (w_frames_inc == r_num);
  assign w_cnt_inc    = r_cnt + LEN_W'(1);
  assign w_pay_last   = r_len - LEN_W'(MIN_LEN);
  assign w_gap_last   = LEN_W'(r_gap) - LEN_W'(1);
  assign w_hdr0       = (r_state == HDR) && (r_cnt == '0);
  assign w_in_frame   = (r_state == HDR) || (r_state == PAY) || (r_state == TRL);

  // Priority is chosen as each frame begins; the first frame of an alternating run is high
  assign w_mode    = w_accept ? cfg_pri_mode : r_mode;
  assign w_alt_cur = w_accept | r_alt;
  assign w_pri_nx  = (w_mode == PRI_LO)  ? 1'b0 :
                     (w_mode == PRI_HI)  ? 1'b1 :
                     (w_mode == PRI_ALT) ? w_alt_cur : w_lfsr_bit;

  xmit_prio_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .i_adv (w_new && (w_mode == PRI_RAND)),
    .o_bit (w_lfsr_bit)
  );

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_nx;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_new       = 1'b0;
    w_exit      = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        if (cfg_len < LEN_W'(MIN_LEN)) w_err = 1'b1;
        else begin
          w_accept   = 1'b1;
          w_new      = 1'b1;
          w_state_nx = HDR;
          w_cnt_nx   = '0;
        end
      end
      HDR: if (w_go) begin
        w_cnt_nx = w_cnt_inc;
        if (r_cnt == LEN_W'(HDR_LEN - 1)) begin
          w_state_nx = PAY;
          w_cnt_nx   = '0;
        end
      end
      PAY: if (w_go) begin
        w_cnt_nx = w_cnt_inc;
        if (r_cnt == w_pay_last) begin
          w_state_nx = TRL;
          w_cnt_nx   = '0;
        end
      end
      TRL: if (w_go) begin
        w_cnt_nx = w_cnt_inc;
        if (r_cnt == LEN_W'(TRL_LEN - 1)) begin
          w_frame_end = 1'b1;
          w_cnt_nx    = '0;
          w_exit      = w_last | w_abort;
          w_new       = ~w_exit && (r_gap == '0);
          w_state_nx  = w_exit ? IDLE : w_new ? HDR : GAP;
        end
      end
      GAP: if (w_go) begin
        w_cnt_nx   = (w_abort || r_cnt == w_gap_last) ? '0 : w_cnt_inc;
        w_exit     = w_abort;
        w_new      = ~w_abort && (r_cnt == w_gap_last);
        w_state_nx = w_exit ? IDLE : w_new ? HDR : GAP;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_num     <= '0;
      r_gap     <= '0;
      r_mode    <= PRI_LO;
      r_frames  <= '0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_pri     <= 1'b0;
      r_alt     <= 1'b0;
      r_disc    <= '0;
    end else begin
      r_cnt <= w_cnt_nx;
      if (w_accept) begin
        r_len  <= cfg_len;
        r_num  <= cfg_num_frames;
        r_gap  <= cfg_gap;
        r_mode <= cfg_pri_mode;
      end
      r_frames  <= w_accept ? '0 : w_frame_end ? w_frames_inc : r_frames;
      r_abort   <= (w_accept || w_exit) ? 1'b0 : r_abort | (abort && r_state != IDLE);
      r_done    <= w_exit;
      r_cfg_err <= w_err;
      if (w_new) begin
        r_pri <= w_pri_nx;
        r_alt <= ~w_alt_cur;
      end
      r_disc <= r_disc + CNT_W'(m_discard_en && r_disc != '1);
    end

  assign f_rec_data_valid  = w_in_frame && w_go;
  assign f_rec_frame_valid = w_hdr0 && w_go;
  assign f_ctrl_in         = w_hdr0 ? (2*LEN_W)'(ctrl_blk(32'(r_len), LEN_W)) : '0;
  assign f_data_in         = (r_state == HDR) ? DATA_W'(HDR_BYTE) :
                             (r_state == PAY) ? r_frames[DATA_W-1:0] :
                             (r_state == TRL) ? DATA_W'(TRL_BYTE) : '0;
  assign f_hi_priority     = r_pri;
  assign busy              = r_state != IDLE;
  assign done              = r_done;
  assign cfg_err           = r_cfg_err;
  assign frames_sent       = r_frames;
  assign discard_cnt       = r_disc;
endmodule

// File: tb/tb_xmit_frame_gen.sv
// tb_xmit_frame_gen: randomized bench comparing the generator against a frame-position reference model
module tb_xmit_frame_gen;
  localparam int DW = 8, LW = 12, CW = 16, HL = 4, TL = 4;
  logic clk_sys = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, stall = 1'b0, m_discard_en = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_num_frames = '0;
  logic [7:0]    cfg_gap = '0;
  logic [1:0]    cfg_pri_mode = '0;
  logic [DW-1:0]   f_data_in;
  logic            f_rec_data_valid, f_rec_frame_valid, f_hi_priority, busy, done, cfg_err;
  logic [2*LW-1:0] f_ctrl_in;
  logic [CW-1:0]   frames_sent, discard_cnt;
  int n_tests = 0, n_fail = 0;
  int n_valid, n_fv, n_busy, n_err;
  logic [7:0]      pri_hist;
  logic [2*LW-1:0] last_ctrl;

  always #5 clk_sys = ~clk_sys;

  xmit_frame_gen dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall),
    .cfg_len(cfg_len), .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap), .cfg_pri_mode(cfg_pri_mode),
    .m_discard_en(m_discard_en), .f_data_in(f_data_in), .f_rec_data_valid(f_rec_data_valid),
    .f_rec_frame_valid(f_rec_frame_valid), .f_ctrl_in(f_ctrl_in), .f_hi_priority(f_hi_priority),
    .busy(busy), .done(done), .cfg_err(cfg_err), .frames_sent(frames_sent), .discard_cnt(discard_cnt)
  );

  // Reference model: a run is a sequence of frames, each occupying positions 0..len+gap-1
  bit m_busy, m_done, m_err, m_pri, m_abort;
  int m_len, m_gap, m_p;
  logic [CW-1:0] m_num, m_k, m_disc;
  logic [1:0]    m_mode;
  logic [15:0]   m_lfsr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_pri = 0; m_abort = 0;
    m_len = 0; m_gap = 0; m_p = 0; m_num = '0; m_k = '0; m_disc = '0; m_mode = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic m_new_frame();
    case (m_mode)
      2'd0: m_pri = 1'b0;
      2'd1: m_pri = 1'b1;
      2'd2: m_pri = ~m_k[0];
      default: begin
        m_pri  = m_lfsr[0];
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    endcase
  endtask

  task automatic m_end_run();
    m_busy = 0; m_done = 1; m_abort = 0;
  endtask

  task automatic m_step(input bit s, input bit st, input bit ab, input bit dis);
    bit abn;
    m_done = 0;
    m_err  = 0;
    if (dis && m_disc != '1) m_disc++;
    if (!m_busy) begin
      if (st) begin
        if (int'(cfg_len) < HL + TL + 1) m_err = 1;
        else begin
          m_busy = 1; m_len = int'(cfg_len); m_num = cfg_num_frames; m_gap = int'(cfg_gap);
          m_mode = cfg_pri_mode; m_k = '0; m_p = 0; m_abort = 0;
          m_new_frame();
        end
      end
    end else begin
      abn = m_abort || ab;
      if (ab) m_abort = 1;
      if (!s) begin
        if (m_p == m_len - 1) begin
          m_k++;
          if ((m_num != 0 && m_k == m_num) || abn) m_end_run();
          else if (m_gap == 0) begin m_p = 0; m_new_frame(); end
          else m_p++;
        end else if (m_p >= m_len && abn) m_end_run();
        else if (m_p == m_len + m_gap - 1) begin m_p = 0; m_new_frame(); end
        else m_p++;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit st, input bit ab, input bit dis);
    bit inf;
    logic [DW-1:0] ed;
    @(negedge clk_sys);
    stall = s; start = st; abort = ab; m_discard_en = dis;
    #1;
    inf = m_busy && m_p < m_len;
    ed = '0;
    if (inf && m_p < HL) ed = '1;
    else if (inf && m_p < m_len - TL) ed = m_k[DW-1:0];
    check("valid", 64'(f_rec_data_valid), 64'(inf && !s));
    check("data", 64'(f_data_in), 64'(ed));
    check("frame_valid", 64'(f_rec_frame_valid), 64'(m_busy && m_p == 0 && !s));
    check("ctrl", 64'(f_ctrl_in), (m_busy && m_p == 0) ? 64'((m_len << LW) | m_len) : 64'd0);
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("cfg_err", 64'(cfg_err), 64'(m_err));
    check("frames_sent", 64'(frames_sent), 64'(m_k));
    check("discard_cnt", 64'(discard_cnt), 64'(m_disc));
    if (inf) check("priority", 64'(f_hi_priority), 64'(m_pri));
    n_valid += int'(f_rec_data_valid);
    n_busy  += int'(busy);
    n_err   += int'(cfg_err);
    if (f_rec_frame_valid) begin
      n_fv++;
      pri_hist  = {pri_hist[6:0], f_hi_priority};
      last_ctrl = f_ctrl_in;
    end
    @(posedge clk_sys);
    #1;
    m_step(s, st, ab, dis);
  endtask

  task automatic clr();
    n_valid = 0; n_fv = 0; n_busy = 0; n_err = 0; pri_hist = '0; last_ctrl = '0;
  endtask

  task automatic go(input int len, input int num, input int gap, input int mode);
    cfg_len = LW'(len); cfg_num_frames = CW'(num); cfg_gap = 8'(gap); cfg_pri_mode = 2'(mode);
    cyc(0, 1, 0, 0);
  endtask

  task automatic run(input int budget, input int stall_pct, input int abort_at);
    int i = 0;
    while (m_busy && i < budget) begin
      cyc($urandom_range(99) < stall_pct, 0, i == abort_at, $urandom_range(9) == 0);
      i++;
    end
    check("run_timeout", 64'(busy), 64'd0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    #2;
    reset_n = 0; start = 0; abort = 0; stall = 0; m_discard_en = 0;
    #1;
    check("rst_valid", 64'(f_rec_data_valid), 64'd0);
    check("rst_fv", 64'(f_rec_frame_valid), 64'd0);
    check("rst_data", 64'(f_data_in), 64'd0);
    check("rst_ctrl", 64'(f_ctrl_in), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pri", 64'(f_hi_priority), 64'd0);
    check("rst_frames", 64'(frames_sent), 64'd0);
    check("rst_disc", 64'(discard_cnt), 64'd0);
    m_reset();
    repeat (2) @(negedge clk_sys);
    reset_n = 1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    clr();
    do_reset();
    repeat (3) cyc(0, 0, 0, 0);

    clr();
    go(512, 64, 0, 1);
    run(40000, 0, -1);
    check("t1_ctrl", 64'(last_ctrl), 64'h200200);
    check("t1_strobes", 64'(n_fv), 64'd64);
    check("t1_valid", 64'(n_valid), 64'd32768);
    check("t1_frames", 64'(frames_sent), 64'd64);

    clr();
    go(9, 3, 5, 2);
    run(200, 0, -1);
    check("t2_valid", 64'(n_valid), 64'd27);
    check("t2_pri", 64'(pri_hist[2:0]), 64'b101);

    clr();
    cyc(0, 0, 1, 0);
    go(8, 5, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);
    check("t3_err", 64'(n_err), 64'd1);
    check("t3_valid", 64'(n_valid), 64'd0);
    check("t3_busy", 64'(n_busy), 64'd0);

    clr();
    go(20, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    run(100, 0, -1);
    check("t4_strobes", 64'(n_fv), 64'd1);
    check("t4_valid", 64'(n_valid), 64'd20);
    check("t4_busy", 64'(n_busy), 64'd26);

    clr();
    go(12, 0, 0, 3);
    run(5000, 0, 300 * 12 + 5);
    check("t5_frames", 64'(frames_sent), 64'd301);
    check("t5_strobes", 64'(n_fv), 64'd301);

    for (int r = 0; r < 12; r++) begin
      int num, ab;
      num = int'($urandom_range(6));
      ab  = (num == 0) ? int'($urandom_range(200, 30)) :
            ($urandom_range(3) == 0) ? int'($urandom_range(150)) : -1;
      go(int'($urandom_range(40, 9)), num, int'($urandom_range(4)), int'($urandom_range(3)));
      run(3000, 20, ab);
    end

    go(30, 2, 0, 1);
    repeat (10) cyc(0, 0, 0, 0);
    do_reset();
    repeat (2) cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("t6_disc", 64'(discard_cnt), 64'd5);
    force dut.r_disc = 16'hFFFD;
    #1;
    release dut.r_disc;
    m_disc = 16'hFFFD;
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("t6_sat", 64'(discard_cnt), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
